// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU control encodings and the
// architectural index of register a0.
package cpu_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_EQ  = 1'b1;

   localparam int REG_A0 = 10;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with same-cycle
// write forwarding, one write port, x0 hard-wired to zero, and an a0 tap.
module reg_file #(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] wd,
   input  logic [ADDR_WIDTH-1:0] rs1,
   input  logic [ADDR_WIDTH-1:0] rs2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic [DATA_WIDTH-1:0] a0
);
   import cpu_pkg::*;

   localparam int NREGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREGS];

   // NOTE: the whole array is reset because reset must leave every register
   // reading zero; this forces flops rather than a RAM macro, which is fine at 32 entries.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (we && rd != '0) begin
         regs[rd] <= wd;
      end
   end

   // A write landing this cycle is forwarded so decode never sees a stale value.
   assign rdata1 = (rs1 == '0)          ? '0 :
                   (we && rd == rs1)    ? wd : regs[rs1];
   assign rdata2 = (rs2 == '0)          ? '0 :
                   (we && rd == rs2)    ? wd : regs[rs2];

   assign a0 = regs[REG_A0];

endmodule

// File: rtl/operand_stage.sv
// Operand-fetch stage: reads the register file, selects register or immediate
// for operand 2 and holds the result in a one-entry valid/ready pipeline register.
module operand_stage
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [ADDR_WIDTH-1:0]        rs1,
   input  logic [ADDR_WIDTH-1:0]        rs2,
   input  logic [DATA_WIDTH-1:0]        imm,
   input  logic                         ALUsrc,
   input  logic                         ALUctrl_in,
   input  logic                         we,
   input  logic [ADDR_WIDTH-1:0]        rd,
   input  logic [DATA_WIDTH-1:0]        wd,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] ALUop1,
   output logic signed [DATA_WIDTH-1:0] ALUop2,
   output logic                         ALUctrl,
   output logic [DATA_WIDTH-1:0]        a0
);

   logic [DATA_WIDTH-1:0] rdata1;
   logic [DATA_WIDTH-1:0] rdata2;
   logic [DATA_WIDTH-1:0] op2;
   logic                  accept;

   reg_file #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_reg_file (
      .clk    (clk),
      .rst    (rst),
      .we     (we),
      .rd     (rd),
      .wd     (wd),
      .rs1    (rs1),
      .rs2    (rs2),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .a0     (a0)
   );

   assign op2      = ALUsrc ? imm : rdata2;
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // NOTE: non-blocking assignments keep every register sampling pre-edge
   // values, so accept and drain in the same cycle resolve without ordering races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         ALUop1    <= '0;
         ALUop2    <= '0;
         ALUctrl   <= ALU_ADD;
      end else if (accept) begin
         out_valid <= 1'b1;
         ALUop1    <= rdata1;
         ALUop2    <= op2;
         ALUctrl   <= ALUctrl_in;
      end else if (out_ready) begin
         // Drain: operands keep their last values, only the valid flag drops.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a vector table for single-cycle behaviour
// plus hand-written sequences for back-pressure and asynchronous reset.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm, wd;
   logic        ALUsrc, ALUctrl_in, we;
   logic        out_valid, out_ready;
   logic signed [31:0] ALUop1, ALUop2;
   logic        ALUctrl;
   logic [31:0] a0;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   operand_stage dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs1        (rs1),
      .rs2        (rs2),
      .imm        (imm),
      .ALUsrc     (ALUsrc),
      .ALUctrl_in (ALUctrl_in),
      .we         (we),
      .rd         (rd),
      .wd         (wd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUop1     (ALUop1),
      .ALUop2     (ALUop2),
      .ALUctrl    (ALUctrl),
      .a0         (a0)
   );

   typedef struct {
      logic        in_valid;
      logic [4:0]  rs1, rs2;
      logic [31:0] imm;
      logic        alusrc, ctrl, we;
      logic [4:0]  rd;
      logic [31:0] wd;
      logic        out_ready;
      logic        e_ov;
      logic [31:0] e_op1, e_op2;
      logic        e_ctrl;
      logic [31:0] e_a0;
      logic        e_ir;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] im, input logic src, input logic ctl,
                         input logic w, input logic [4:0] d, input logic [31:0] data,
                         input logic ordy);
      in_valid = v;   rs1 = r1;  rs2 = r2;  imm = im;  ALUsrc = src;
      ALUctrl_in = ctl; we = w;  rd = d;    wd = data; out_ready = ordy;
   endtask

   task automatic add_vec(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [31:0] im, input logic src, input logic ctl,
                          input logic w, input logic [4:0] d, input logic [31:0] data,
                          input logic ordy, input logic eov, input logic [31:0] eop1,
                          input logic [31:0] eop2, input logic ectl, input logic [31:0] ea0,
                          input logic eir);
      vec_t t;
      t.in_valid = v;  t.rs1 = r1;  t.rs2 = r2;  t.imm = im;  t.alusrc = src;
      t.ctrl = ctl;    t.we = w;    t.rd = d;    t.wd = data; t.out_ready = ordy;
      t.e_ov = eov;    t.e_op1 = eop1; t.e_op2 = eop2; t.e_ctrl = ectl;
      t.e_a0 = ea0;    t.e_ir = eir;
      vecs.push_back(t);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

      //        v  rs1 rs2 imm           src ctl we rd data          ordy | ov op1           op2           ctl a0     ir
      add_vec(0, 0,  0,  32'h0,        0,  0,  1, 5, 32'h0000_1234, 1,    0, 32'h0,        32'h0,        0,  32'd0, 1);
      add_vec(0, 0,  0,  32'h0,        0,  0,  1, 0, 32'hFFFF_FFFF, 1,    0, 32'h0,        32'h0,        0,  32'd0, 1);
      add_vec(1, 5,  0,  32'h0,        0,  0,  0, 0, 32'h0,         1,    1, 32'h0000_1234, 32'h0,       0,  32'd0, 1);
      add_vec(1, 7,  0,  32'hFFFF_FFF8, 1, 1,  1, 7, 32'd42,        1,    1, 32'd42,       32'hFFFF_FFF8, 1, 32'd0, 1);
      add_vec(1, 10, 7,  32'h0,        0,  0,  1, 10, 32'd99,       1,    1, 32'd99,       32'd42,       0,  32'd99, 1);
      add_vec(1, 0,  3,  32'h0,        0,  1,  1, 3, 32'hDEAD_BEEF, 1,    1, 32'h0,        32'hDEAD_BEEF, 1, 32'd99, 1);
      add_vec(1, 0,  0,  32'h0,        0,  0,  1, 0, 32'd5,         1,    1, 32'h0,        32'h0,        0,  32'd99, 1);
      add_vec(1, 3,  5,  32'h0,        0,  1,  0, 0, 32'h0,         1,    1, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'd99, 1);
      add_vec(0, 0,  0,  32'h0,        0,  0,  0, 0, 32'h0,         1,    0, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'd99, 1);
      add_vec(0, 0,  0,  32'h0,        0,  0,  0, 0, 32'h0,         0,    0, 32'hDEAD_BEEF, 32'h0000_1234, 1, 32'd99, 1);

      repeat (2) @(negedge clk);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_in_ready",  {31'b0, in_ready},  32'd1);
      check("reset_op1",       ALUop1,             32'd0);
      check("reset_a0",        a0,                 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         set_in(vecs[i].in_valid, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].alusrc,
                vecs[i].ctrl, vecs[i].we, vecs[i].rd, vecs[i].wd, vecs[i].out_ready);
         @(posedge clk);
         #2;
         check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
         check($sformatf("v%0d_op1", i),       ALUop1,              vecs[i].e_op1);
         check($sformatf("v%0d_op2", i),       ALUop2,              vecs[i].e_op2);
         check($sformatf("v%0d_ctrl", i),      {31'b0, ALUctrl},    {31'b0, vecs[i].e_ctrl});
         check($sformatf("v%0d_a0", i),        a0,                  vecs[i].e_a0);
         check($sformatf("v%0d_in_ready", i),  {31'b0, in_ready},   {31'b0, vecs[i].e_ir});
         @(negedge clk);
      end

      // Back-pressure: A held for three stalled cycles while B waits.
      set_in(1, 5, 10, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      @(posedge clk); #2;
      check("bp_accept_a_op1", ALUop1, 32'h0000_1234);
      check("bp_accept_a_op2", ALUop2, 32'd99);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         set_in(1, 7, 0, 32'h55, 1, 1, (k == 0), 5, 32'h777, 0);
         @(posedge clk); #2;
         check($sformatf("bp_stall%0d_in_ready", k),  {31'b0, in_ready},  32'd0);
         check($sformatf("bp_stall%0d_out_valid", k), {31'b0, out_valid}, 32'd1);
         check($sformatf("bp_stall%0d_op1", k),       ALUop1,             32'h0000_1234);
         check($sformatf("bp_stall%0d_op2", k),       ALUop2,             32'd99);
         check($sformatf("bp_stall%0d_ctrl", k),      {31'b0, ALUctrl},   32'd0);
         @(negedge clk);
      end
      set_in(1, 7, 0, 32'h55, 1, 1, 0, 0, 32'h0, 1);
      #1;
      check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #2;
      check("bp_b_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_b_op1",       ALUop1,             32'd42);
      check("bp_b_op2",       ALUop2,             32'h55);
      check("bp_b_ctrl",      {31'b0, ALUctrl},   32'd1);
      @(negedge clk);

      // The write made during the stall is now visible in the register file.
      set_in(1, 5, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      @(posedge clk); #2;
      check("stall_write_visible", ALUop1, 32'h0000_0777);
      @(negedge clk);

      // Asynchronous reset while stalled, between clock edges.
      set_in(0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0);
      @(posedge clk); #2;
      check("pre_rst_held_valid", {31'b0, out_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("async_rst_op1",       ALUop1,             32'd0);
      check("async_rst_op2",       ALUop2,             32'd0);
      check("async_rst_a0",        a0,                 32'd0);
      check("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Reset then read: every register cleared, first accept immediately.
      set_in(1, 3, 4, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      @(posedge clk); #2;
      check("post_rst_out_valid", {31'b0, out_valid}, 32'd1);
      check("post_rst_op1",       ALUop1,             32'd0);
      check("post_rst_op2",       ALUop2,             32'd0);
      check("post_rst_a0",        a0,                 32'd0);
      @(negedge clk);
      set_in(1, 5, 10, 32'h0, 0, 0, 0, 0, 32'h0, 1);
      @(posedge clk); #2;
      check("post_rst_r5",  ALUop1, 32'd0);
      check("post_rst_r10", ALUop2, 32'd0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
